sat_down_cntr_bank: RTL and testbench

SAT_DOWN_CNTR_BANK -- requirements
Module: sat_down_cntr_bank

---
 rtl/sat_down_cntr_bank_if.sv | 26 ++
 rtl/sat_down_cntr_bank.sv | 71 +++++++
 tb/tb_sat_down_cntr_bank.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sat_down_cntr_bank_if.sv
// Bundle of load/mode/status signals for the saturating down-counter bank.
// The master drives load requests, load values, reload modes and the global
// enable; the slave (the counter bank) returns per-channel status flags.
// Load is a level request, and the bank acts only on its rising edge.
interface sat_down_cntr_bank_if #(
    parameter int NUM_CNTR_BITS = 5,
    parameter int NUM_CHANNELS  = 4
);
    logic [NUM_CHANNELS-1:0]               load;
    logic [NUM_CHANNELS*NUM_CNTR_BITS-1:0] cntrInput;
    logic [NUM_CHANNELS-1:0]               autoReload;
    logic                                  enable;
    logic [NUM_CHANNELS-1:0]               zeroed;
    logic [NUM_CHANNELS-1:0]               terminalPulse;
    logic                                  allZeroed;

    modport master (
        output load, cntrInput, autoReload, enable,
        input  zeroed, terminalPulse, allZeroed
    );

    modport slave (
        input  load, cntrInput, autoReload, enable,
        output zeroed, terminalPulse, allZeroed
    );
endinterface

// File: rtl/sat_down_cntr_bank.sv
// Bank of independent saturating down counters.
// Each channel is loaded on the rising edge of its load request. It counts
// down while the global enable is high. When it reaches its terminal
// transition (count 1), it either stops at 0 (one-shot) or reloads
// (periodic), and it emits a one-cycle registered terminal pulse.
module sat_down_cntr_bank #(
    parameter int NUM_CNTR_BITS = 5,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    sat_down_cntr_bank_if.slave   bus
);
    localparam logic [NUM_CNTR_BITS-1:0] ONE  = NUM_CNTR_BITS'(1);
    localparam logic [NUM_CNTR_BITS-1:0] ZERO = '0;

    logic [NUM_CHANNELS-1:0][NUM_CNTR_BITS-1:0] count_q,  count_d;
    logic [NUM_CHANNELS-1:0][NUM_CNTR_BITS-1:0] reload_q, reload_d;
    logic [NUM_CHANNELS-1:0]                    seen_q,   seen_d;
    logic [NUM_CHANNELS-1:0]                    pulse_q,  pulse_d;
    logic [NUM_CHANNELS-1:0]                    zeroed_w;

    // Per-channel next-state: a load edge wins over counting, counting is gated by enable
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        seen_d   = bus.load;
        pulse_d  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (bus.load[i] && !seen_q[i]) begin
                count_d[i]  = bus.cntrInput[i*NUM_CNTR_BITS +: NUM_CNTR_BITS];
                reload_d[i] = bus.cntrInput[i*NUM_CNTR_BITS +: NUM_CNTR_BITS];
            end else if (bus.enable && (count_q[i] != ZERO)) begin
                if (count_q[i] == ONE) begin
                    // Mode is only looked at here, so mid-count changes are harmless
                    count_d[i] = bus.autoReload[i] ? reload_q[i] : ZERO;
                    pulse_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - ONE;
                end
            end
        end
    end

    // State registers; reset aborts counting and drops any pending pulse
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q  <= '0;
            reload_q <= '0;
            seen_q   <= '0;
            pulse_q  <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            seen_q   <= seen_d;
            pulse_q  <= pulse_d;
        end
    end

    // Zero flags follow the count register directly, so they track it in the same cycle
    always_comb begin
        zeroed_w = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            zeroed_w[i] = (count_q[i] == ZERO);
        end
    end

    assign bus.zeroed        = zeroed_w;
    assign bus.allZeroed     = &zeroed_w;
    assign bus.terminalPulse = pulse_q;
endmodule

// File: tb/tb_sat_down_cntr_bank.sv
// Directed bench for the saturating down-counter bank. It covers one-shot
// and periodic counting, held load, a load colliding with the terminal
// transition, the enable freeze, loading zero, allZeroed, and asynchronous
// reset.
module tb_sat_down_cntr_bank;
    localparam int NB = 5;
    localparam int NC = 4;

    logic clock;
    logic resetN;
    int   total;
    int   bad;

    sat_down_cntr_bank_if #(.NUM_CNTR_BITS(NB), .NUM_CHANNELS(NC)) bus ();

    sat_down_cntr_bank #(.NUM_CNTR_BITS(NB), .NUM_CHANNELS(NC)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    // Clock: 10 time-unit period, first rising edge at t=5
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int ch, input logic [NB-1:0] v);
        bus.cntrInput[ch*NB +: NB] = v;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(dut.count_q[ch]);
    endfunction

    initial begin
        int exp_c1 [6];
        int exp_p1 [6];
        total = 0;
        bad   = 0;
        resetN         = 1'b0;
        bus.load       = '0;
        bus.cntrInput  = '0;
        bus.autoReload = '0;
        bus.enable     = 1'b0;

        // Reset state, checked while reset is still held
        #2;
        chk("rst_zeroed", 32'(bus.zeroed), 32'hf);
        chk("rst_allzeroed", 32'(bus.allZeroed), 32'd1);
        chk("rst_pulse", 32'(bus.terminalPulse), 32'd0);
        #10;
        resetN = 1'b1;
        step();
        chk("post_rst_zeroed", 32'(bus.zeroed), 32'hf);

        // One-shot on ch0 with value 3
        set_val(0, 5'd3);
        bus.load[0] = 1'b1;
        bus.enable  = 1'b1;
        step();
        chk("os_load_cnt", cnt(0), 32'd3);
        chk("os_load_zeroed", 32'(bus.zeroed[0]), 32'd0);
        bus.load[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("os_cnt", cnt(0), (k == 0) ? 32'd2 : (k == 1) ? 32'd1 : 32'd0);
            chk("os_pulse", 32'(bus.terminalPulse[0]), (k == 2) ? 32'd1 : 32'd0);
            chk("os_zeroed", 32'(bus.zeroed[0]), (k >= 2) ? 32'd1 : 32'd0);
        end

        // Periodic on ch1 with value 2
        set_val(1, 5'd2);
        bus.autoReload[1] = 1'b1;
        bus.load[1]       = 1'b1;
        step();
        chk("per_load_cnt", cnt(1), 32'd2);
        bus.load[1] = 1'b0;
        exp_c1 = '{1, 2, 1, 2, 1, 2};
        exp_p1 = '{0, 1, 0, 1, 0, 1};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("per_cnt", cnt(1), 32'(exp_c1[k]));
            chk("per_pulse", 32'(bus.terminalPulse[1]), 32'(exp_p1[k]));
            chk("per_zeroed", 32'(bus.zeroed[1]), 32'd0);
        end

        // Held load on ch2 with value 5 for 10 cycles
        set_val(2, 5'd5);
        bus.load[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("held_cnt", cnt(2), (k <= 5) ? 32'(6 - k) : 32'd0);
            chk("held_pulse", 32'(bus.terminalPulse[2]), (k == 6) ? 32'd1 : 32'd0);
        end
        set_val(2, 5'd7);
        step();
        chk("held_new_val_ignored", cnt(2), 32'd0);
        bus.load[2] = 1'b0;
        step();
        chk("held_drop_cnt", cnt(2), 32'd0);
        bus.load[2] = 1'b1;
        step();
        chk("held_rearm_cnt", cnt(2), 32'd7);
        bus.load[2] = 1'b0;

        // Collision on ch0: load edge while periodic count is 1
        bus.autoReload[0] = 1'b1;
        set_val(0, 5'd2);
        bus.load[0] = 1'b1;
        step();
        chk("col_load_cnt", cnt(0), 32'd2);
        bus.load[0] = 1'b0;
        step();
        chk("col_pre_cnt", cnt(0), 32'd1);
        set_val(0, 5'd9);
        bus.load[0] = 1'b1;
        step();
        chk("col_cnt", cnt(0), 32'd9);
        chk("col_pulse", 32'(bus.terminalPulse[0]), 32'd0);
        bus.load[0] = 1'b0;
        step();
        chk("col_next_cnt", cnt(0), 32'd8);
        chk("col_next_pulse", 32'(bus.terminalPulse[0]), 32'd0);

        // Enable low for 4 cycles freezes counts, loads still land
        bus.enable = 1'b0;
        step();
        chk("frz_cnt0_a", cnt(0), 32'd8);
        set_val(3, 5'd4);
        bus.load[3] = 1'b1;
        step();
        chk("frz_cnt0_b", cnt(0), 32'd8);
        chk("frz_load3", cnt(3), 32'd4);
        bus.load[3] = 1'b0;
        step();
        chk("frz_cnt0_c", cnt(0), 32'd8);
        step();
        chk("frz_cnt0_d", cnt(0), 32'd8);
        chk("frz_cnt3", cnt(3), 32'd4);
        bus.enable = 1'b1;
        step();
        chk("unfrz_cnt0", cnt(0), 32'd7);
        chk("unfrz_cnt3", cnt(3), 32'd3);

        // Loading 0 gives an immediate zero with no pulse; periodic reload of 0 stays at 0
        set_val(0, 5'd0);
        bus.load[0] = 1'b1;
        step();
        chk("ld0_cnt", cnt(0), 32'd0);
        chk("ld0_zeroed", 32'(bus.zeroed[0]), 32'd1);
        chk("ld0_pulse", 32'(bus.terminalPulse[0]), 32'd0);
        chk("ld0_allzeroed", 32'(bus.allZeroed), 32'd0);
        chk("ld0_cnt3", cnt(3), 32'd2);
        bus.load[0] = 1'b0;
        step();
        step();
        chk("ld0_sat_cnt", cnt(0), 32'd0);
        chk("ld0_sat_pulse", 32'(bus.terminalPulse[0]), 32'd0);

        // Zero every channel at once, then one channel runs 1 -> 0
        bus.cntrInput = '0;
        bus.load      = 4'hf;
        step();
        chk("all0_zeroed", 32'(bus.zeroed), 32'hf);
        chk("all0_allzeroed", 32'(bus.allZeroed), 32'd1);
        chk("all0_pulse", 32'(bus.terminalPulse), 32'd0);
        bus.load = '0;
        step();
        set_val(3, 5'd1);
        bus.autoReload[3] = 1'b0;
        bus.load[3]       = 1'b1;
        step();
        chk("one_cnt3", cnt(3), 32'd1);
        chk("one_allzeroed", 32'(bus.allZeroed), 32'd0);
        bus.load[3] = 1'b0;
        step();
        chk("one_term_cnt3", cnt(3), 32'd0);
        chk("one_term_pulse", 32'(bus.terminalPulse), 32'h8);
        chk("one_term_allzeroed", 32'(bus.allZeroed), 32'd1);

        // Reset asserted between clock edges while ch0 is at 1
        set_val(0, 5'd3);
        bus.autoReload[0] = 1'b0;
        bus.load[0]       = 1'b1;
        step();
        chk("rst_pre_cnt_a", cnt(0), 32'd3);
        bus.load[0] = 1'b0;
        step();
        step();
        chk("rst_pre_cnt_b", cnt(0), 32'd1);
        #3;
        resetN = 1'b0;
        #1;
        chk("async_rst_cnt0", cnt(0), 32'd0);
        chk("async_rst_zeroed", 32'(bus.zeroed), 32'hf);
        chk("async_rst_allzeroed", 32'(bus.allZeroed), 32'd1);
        chk("async_rst_pulse", 32'(bus.terminalPulse), 32'd0);
        set_val(1, 5'd3);
        bus.load[1] = 1'b1;
        step();
        chk("in_rst_cnt1", cnt(1), 32'd0);
        resetN = 1'b1;
        step();
        chk("rel_load_cnt1", cnt(1), 32'd3);
        chk("rel_cnt0", cnt(0), 32'd0);
        chk("rel_pulse", 32'(bus.terminalPulse), 32'd0);
        bus.load[1] = 1'b0;
        step();
        chk("rel_next_cnt1", cnt(1), 32'd2);
        chk("rel_next_pulse", 32'(bus.terminalPulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
